// File: rtl/context_quantizer_pkg.sv
// Shared JPEG-LS parameterisation for the context quantizer:
// sample width, gradient width, thresholds and context index helpers.
package context_quantizer_pkg;

    localparam int BIT_DEPTH_DEF = 8;
    localparam int Q_LENGTH_DEF  = 4;
    localparam int T1_DEF        = 3;
    localparam int T2_DEF        = 7;
    localparam int T3_DEF        = 21;
    localparam int CTX_W         = 9;
    localparam int CTX_MAX       = 364;

    // The first non-zero gradient, in order a, b, c, decides the sign.
    function automatic logic first_neg(
        input int a,
        input int b,
        input int c
    );
        if (a != 0) return (a < 0);
        if (b != 0) return (b < 0);
        return (c < 0);
    endfunction

    // Base-9 style packing of three sign-corrected gradients.
    function automatic int ctx_of(
        input int a,
        input int b,
        input int c
    );
        return 81 * a + 9 * b + c;
    endfunction

endpackage

// File: rtl/context_quantizer_gradient_quant.sv
// Maps one signed local gradient onto the nine-level
// quantized range -4..4 using thresholds T1/T2/T3.
module gradient_quant #(
    parameter int DW = 9,
    parameter int QW = 4,
    parameter int T1 = 3,
    parameter int T2 = 7,
    parameter int T3 = 21
) (
    input  logic signed [DW-1:0] d,
    output logic signed [QW-1:0] q
);

    int dv;

    // Threshold ladder, most negative bucket first.
    always_comb begin
        dv = int'(d);
        q  = '0;
        if (dv <= -T3)      q = QW'(-4);
        else if (dv <= -T2) q = QW'(-3);
        else if (dv <= -T1) q = QW'(-2);
        else if (dv < 0)    q = QW'(-1);
        else if (dv == 0)   q = QW'(0);
        else if (dv < T1)   q = QW'(1);
        else if (dv < T2)   q = QW'(2);
        else if (dv < T3)   q = QW'(3);
        else                q = QW'(4);
    end

endmodule

// File: rtl/context_quantizer.sv
// Two-stage JPEG-LS context quantizer: gradients, then quantize/sign/index.
// Optional RUN_MODE_DETECT_EN flags the flat (all-zero gradient) context.
module context_quantizer
    import context_quantizer_pkg::*;
#(
    parameter int BIT_DEPTH = BIT_DEPTH_DEF,
    parameter int Q_length  = Q_LENGTH_DEF,
    parameter int T1        = T1_DEF,
    parameter int T2        = T2_DEF,
    parameter int T3        = T3_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_DEPTH-1:0] Ra,
    input  logic [BIT_DEPTH-1:0] Rb,
    input  logic [BIT_DEPTH-1:0] Rc,
    input  logic [BIT_DEPTH-1:0] Rd,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [Q_length-1:0]  Q_1,
    output logic [Q_length-1:0]  Q_2,
    output logic [Q_length-1:0]  Q_3,
    output logic                 sign,
    output logic [CTX_W-1:0]     ctx_idx,
    output logic                 run_flag,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int DW = BIT_DEPTH + 1;

    logic                en;
    logic                v1;
    logic signed [DW-1:0] d1;
    logic signed [DW-1:0] d2;
    logic signed [DW-1:0] d3;

    logic signed [Q_length-1:0] q1;
    logic signed [Q_length-1:0] q2;
    logic signed [Q_length-1:0] q3;
    logic signed [Q_length-1:0] c1;
    logic signed [Q_length-1:0] c2;
    logic signed [Q_length-1:0] c3;
    logic                       sgn_n;
    logic [CTX_W-1:0]           idx_n;
    logic                       run_n;

    // Whole pipe moves together; a held output freezes both stages.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: zero-extend the samples and form the three gradients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= $signed({1'b0, Rd}) - $signed({1'b0, Rb});
                d2 <= $signed({1'b0, Rb}) - $signed({1'b0, Rc});
                d3 <= $signed({1'b0, Rc}) - $signed({1'b0, Ra});
            end
        end
    end

    gradient_quant #(
        .DW (DW),
        .QW (Q_length),
        .T1 (T1),
        .T2 (T2),
        .T3 (T3)
    ) u_gq1 (
        .d (d1),
        .q (q1)
    );

    gradient_quant #(
        .DW (DW),
        .QW (Q_length),
        .T1 (T1),
        .T2 (T2),
        .T3 (T3)
    ) u_gq2 (
        .d (d2),
        .q (q2)
    );

    gradient_quant #(
        .DW (DW),
        .QW (Q_length),
        .T1 (T1),
        .T2 (T2),
        .T3 (T3)
    ) u_gq3 (
        .d (d3),
        .q (q3)
    );

    // Fold the context onto its positive half and pack the index.
    always_comb begin
        sgn_n = first_neg(int'(q1), int'(q2), int'(q3));
        c1    = sgn_n ? -q1 : q1;
        c2    = sgn_n ? -q2 : q2;
        c3    = sgn_n ? -q3 : q3;
        idx_n = CTX_W'(ctx_of(int'(c1), int'(c2), int'(c3)));
    end

`ifdef RUN_MODE_DETECT_EN
    assign run_n = (d1 == '0) && (d2 == '0) && (d3 == '0);
`else
    assign run_n = 1'b0;
`endif

    // Stage 2: output registers, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Q_1       <= '0;
            Q_2       <= '0;
            Q_3       <= '0;
            sign      <= 1'b0;
            ctx_idx   <= '0;
            run_flag  <= 1'b0;
        end else if (en) begin
            out_valid <= v1;
            if (v1) begin
                Q_1      <= c1;
                Q_2      <= c2;
                Q_3      <= c3;
                sign     <= sgn_n;
                ctx_idx  <= idx_n;
                run_flag <= run_n;
            end
        end
    end

endmodule

// File: tb/tb_context_quantizer.sv
// Self-checking bench for context_quantizer: directed cases plus
// randomized traffic scored against a behavioural reference model.
module tb_context_quantizer;

    localparam int T1 = 3;
    localparam int T2 = 7;
    localparam int T3 = 21;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] Ra, Rb, Rc, Rd;
    logic       in_valid, in_ready;
    logic [3:0] Q_1, Q_2, Q_3;
    logic       sign;
    logic [8:0] ctx_idx;
    logic       run_flag;
    logic       out_valid, out_ready;

    typedef struct {
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        logic       s;
        logic [8:0] idx;
        logic       run;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

`ifdef RUN_MODE_DETECT_EN
    localparam logic RUN_EXP = 1'b1;
`else
    localparam logic RUN_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    context_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ra        (Ra),
        .Rb        (Rb),
        .Rc        (Rc),
        .Rd        (Rd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q_1       (Q_1),
        .Q_2       (Q_2),
        .Q_3       (Q_3),
        .sign      (sign),
        .ctx_idx   (ctx_idx),
        .run_flag  (run_flag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int quant(input int d);
        if (d <= -T3) return -4;
        if (d <= -T2) return -3;
        if (d <= -T1) return -2;
        if (d < 0)    return -1;
        if (d == 0)   return 0;
        if (d < T1)   return 1;
        if (d < T2)   return 2;
        if (d < T3)   return 3;
        return 4;
    endfunction

    function automatic exp_t model(input int ra, input int rb,
                                   input int rc, input int rd);
        exp_t e;
        int   d[3];
        int   q[3];
        logic s;
        logic found;
        d[0] = rd - rb;
        d[1] = rb - rc;
        d[2] = rc - ra;
        s = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q[i] = quant(d[i]);
            if (!found && q[i] != 0) begin
                found = 1'b1;
                s = (q[i] < 0);
            end
        end
        if (s) for (int i = 0; i < 3; i++) q[i] = -q[i];
        e.q1  = 4'(q[0]);
        e.q2  = 4'(q[1]);
        e.q3  = 4'(q[2]);
        e.s   = s;
        e.idx = 9'(81 * q[0] + 9 * q[1] + q[2]);
        e.run = RUN_EXP && !found;
        return e;
    endfunction

    function automatic logic [7:0] near(input int b);
        int v;
        v = b + int'($urandom_range(0, 50)) - 25;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    // One clock: score the output transfer, log the accept, then advance.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_q1", Q_1, e.q1);
                chk("sb_q2", Q_2, e.q2);
                chk("sb_q3", Q_3, e.q3);
                chk("sb_sign", sign, e.s);
                chk("sb_ctx", ctx_idx, e.idx);
                chk("sb_run", run_flag, e.run);
            end
        end
        if (in_valid && in_ready)
            sb.push_back(model(Ra, Rb, Rc, Rd));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ra, input int rb,
                         input int rc, input int rd);
        Ra = 8'(ra);
        Rb = 8'(rb);
        Rc = 8'(rc);
        Rd = 8'(rd);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("drain_empty", 32'(sb.size()), 0);
    endtask

    task automatic direct(input string tag,
                          input int ra, input int rb,
                          input int rc, input int rd,
                          input logic [3:0] e1, input logic [3:0] e2,
                          input logic [3:0] e3, input logic es,
                          input logic [8:0] eidx, input logic erun);
        drive(ra, rb, rc, rd);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        tick();
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_q1"}, Q_1, e1);
        chk({tag, "_q2"}, Q_2, e2);
        chk({tag, "_q3"}, Q_3, e3);
        chk({tag, "_sign"}, sign, es);
        chk({tag, "_ctx"}, ctx_idx, eidx);
        chk({tag, "_run"}, run_flag, erun);
    endtask

    initial begin
        logic [8:0] s_ctx;
        logic [3:0] s_q1;
        logic       s_sg;
        int         b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ctx", ctx_idx, 0);
        chk("rst_sign", sign, 0);
        chk("rst_run", run_flag, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        direct("basic", 100, 110, 100, 130, 4'd3, 4'd3, 4'd0,
               1'b0, 9'd270, 1'b0);
        direct("signrev", 100, 100, 105, 90, 4'd3, 4'd2, 4'hE,
               1'b1, 9'd259, 1'b0);
        direct("max", 0, 0, 0, 255, 4'd4, 4'd0, 4'd0,
               1'b0, 9'd324, 1'b0);
        direct("d1_20", 0, 0, 0, 20, 4'd3, 4'd0, 4'd0,
               1'b0, 9'd243, 1'b0);
        direct("d1_21", 0, 0, 0, 21, 4'd4, 4'd0, 4'd0,
               1'b0, 9'd324, 1'b0);
        direct("flat", 50, 50, 50, 50, 4'd0, 4'd0, 4'd0,
               1'b0, 9'd0, RUN_EXP);
        drain();

        // Stall: two results in flight, downstream blocked.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(10, 40, 30, 5);
        tick();
        drive(200, 190, 195, 201);
        tick();
        chk("stall_pre_valid", out_valid, 1);
        out_ready = 1'b0;
        drive(7, 8, 9, 10);
        s_ctx = ctx_idx;
        s_q1  = Q_1;
        s_sg  = sign;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_ctx", ctx_idx, s_ctx);
            chk("stall_q1", Q_1, s_q1);
            chk("stall_sign", sign, s_sg);
        end
        drain();
        chk("stall_no_dup", out_valid, 0);

        // Sustained throughput.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            drive($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
            tick();
            if (k >= 1) chk("thru_valid", out_valid, 1);
            chk("thru_in_ready", in_ready, 1);
        end
        drain();

        // Reset with both stages full.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(1, 60, 2, 90);
        tick();
        drive(90, 3, 70, 4);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("prerst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ctx", ctx_idx, 0);
        chk("midrst_sign", sign, 0);
        chk("midrst_run", run_flag, 0);
        sb.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("postrst_no_stale", out_valid, 0);
        end

        // Randomized traffic with near-threshold neighbourhoods.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: drive($urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255), $urandom_range(0, 255));
                1: begin
                    b = int'($urandom_range(0, 255));
                    drive(near(b), near(b), near(b), near(b));
                end
                default: begin
                    b = int'($urandom_range(0, 255));
                    drive(b, b, b, near(b));
                end
            endcase
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
